// File: rtl/turbo_block_encoder.sv
// Rate-1/3 turbo block encoder: two 8-state RSC encoders, linear-congruential
// interleaver, three-triple trellis termination per block.
module turbo_block_encoder #(
  parameter int BLOCK_LEN = 16,
  parameter int INTLV_A   = 5,
  parameter int INTLV_B   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_data,
  output logic       out_tail,
  output logic       out_last
);

  localparam int LW = $clog2(BLOCK_LEN);
  localparam logic [LW-1:0] LAST = LW'(BLOCK_LEN - 1);
  localparam logic [LW-1:0] TWO  = LW'(2);
  localparam logic [LW-1:0] A_L  = LW'(INTLV_A);
  localparam logic [LW-1:0] B_L  = LW'(INTLV_B);

  typedef enum logic [1:0] {
    LOAD,
    ENCODE,
    TAIL
  } state_e;

  state_e               state_q, state_d;
  logic [LW-1:0]        cnt_q, cnt_d;
  logic [LW-1:0]        idx_q, idx_d;
  logic [2:0]           s1_q, s1_d;
  logic [2:0]           s2_q, s2_d;
  logic [BLOCK_LEN-1:0] buf_q, buf_d;

  logic u1, u2, a1, a2, p1, p2;
  logic accept, fire;

  assign accept = in_valid & in_ready;
  assign fire   = out_valid & out_ready;

  // In TAIL the input is chosen so the feedback a is zero, flushing the state.
  always_comb begin
    u1 = buf_q[cnt_q];
    u2 = buf_q[idx_q];
    if (state_q == TAIL) begin
      u1 = s1_q[1] ^ s1_q[2];
      u2 = s2_q[1] ^ s2_q[2];
    end
    a1 = u1 ^ s1_q[1] ^ s1_q[2];
    a2 = u2 ^ s2_q[1] ^ s2_q[2];
    p1 = a1 ^ s1_q[0] ^ s1_q[2];
    p2 = a2 ^ s2_q[0] ^ s2_q[2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      idx_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    buf_d   = buf_q;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          buf_d[cnt_q] = in_bit;
          if (cnt_q == LAST) begin
            state_d = ENCODE;
            cnt_d   = '0;
            idx_d   = B_L;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ENCODE: begin
        if (fire) begin
          s1_d  = {s1_q[1:0], a1};
          s2_d  = {s2_q[1:0], a2};
          idx_d = idx_q + A_L;
          if (cnt_q == LAST) begin
            state_d = TAIL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      TAIL: begin
        if (fire) begin
          s1_d = {s1_q[1:0], a1};
          s2_d = {s2_q[1:0], a2};
          if (cnt_q == TWO) begin
            state_d = LOAD;
            cnt_d   = '0;
            idx_d   = '0;
            s1_d    = '0;
            s2_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = ~reset & (state_q == LOAD);
    out_valid = ~reset & (state_q != LOAD);
    out_data  = out_valid ? {p2, p1, u1} : 3'b000;
    out_tail  = out_valid & (state_q == TAIL);
    out_last  = out_tail & (cnt_q == TWO);
  end

endmodule

// File: tb/tb_turbo_block_encoder.sv
// Scoreboard bench for turbo_block_encoder (BLOCK_LEN=8, A=5, B=3).
// Independent RSC/interleaver model fills the queue; DUT triples drain it.
module tb_turbo_block_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       out_ready = 1'b1;
  logic       in_ready;
  logic       out_valid;
  logic [2:0] out_data;
  logic       out_tail;
  logic       out_last;

  always #5 clk = ~clk;

  turbo_block_encoder #(
    .BLOCK_LEN(8),
    .INTLV_A  (5),
    .INTLV_B  (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tail (out_tail),
    .out_last (out_last)
  );

  typedef struct packed {
    logic [2:0] d;
    logic       t;
    logic       l;
  } trip_t;

  trip_t      sb[$];
  int         nvec = 0;
  int         nerr = 0;
  int         pops = 0;
  bit         hold_pend = 0;
  logic [5:0] hold_v = '0;
  bit         chk_first = 0;
  bit         in_load = 0;
  bit         after_last = 0;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] rsc(input logic [2:0] s, input logic u);
    logic a;
    a = u ^ s[1] ^ s[2];
    return {a ^ s[0] ^ s[2], s[1], s[0], a};
  endfunction

  task automatic push_model(input logic [7:0] b);
    logic [2:0] s1 = '0;
    logic [2:0] s2 = '0;
    logic [3:0] r1, r2;
    logic       u1, u2;
    for (int i = 0; i < 8; i++) begin
      u1 = b[i];
      u2 = b[(5 * i + 3) % 8];
      r1 = rsc(s1, u1);
      r2 = rsc(s2, u2);
      sb.push_back({r2[3], r1[3], u1, 1'b0, 1'b0});
      s1 = r1[2:0];
      s2 = r2[2:0];
    end
    for (int j = 0; j < 3; j++) begin
      u1 = s1[1] ^ s1[2];
      u2 = s2[1] ^ s2[2];
      r1 = rsc(s1, u1);
      r2 = rsc(s2, u2);
      sb.push_back({r2[3], r1[3], u1, 1'b1, (j == 2)});
      s1 = r1[2:0];
      s2 = r2[2:0];
    end
  endtask

  task automatic cyc(input logic iv, input logic ib, input logic rdy,
                     output bit acc);
    trip_t e;
    @(negedge clk);
    if (chk_first) begin
      chk("first_latency", 8'(out_valid), 8'd1);
      chk_first = 0;
    end
    if (in_load) chk("load_no_valid", 8'(out_valid), 8'd0);
    if (after_last) begin
      chk("ready_after_last", 8'(in_ready), 8'd1);
      chk("s1_zero", 8'(dut.s1_q), 8'd0);
      chk("s2_zero", 8'(dut.s2_q), 8'd0);
      after_last = 0;
    end
    if (out_valid) chk("no_overlap", 8'(in_ready), 8'd0);
    if (hold_pend)
      chk("hold", 8'({out_valid, out_data, out_tail, out_last}), 8'(hold_v));
    acc = iv && in_ready;
    if (out_valid && rdy) begin
      if (sb.size() == 0) begin
        chk("spurious_triple", 8'(out_valid), 8'd0);
      end else begin
        e = sb.pop_front();
        pops++;
        chk("triple", 8'({out_data, out_tail, out_last}), 8'(e));
        if (e.l) after_last = 1;
      end
    end
    hold_pend = out_valid && !rdy;
    hold_v    = {out_valid, out_data, out_tail, out_last};
    in_valid  = iv;
    in_bit    = ib;
    out_ready = rdy;
  endtask

  task automatic load(input logic [7:0] b, input bit gaps);
    bit acc;
    bit v;
    int tries;
    pops    = 0;
    in_load = 1;
    for (int i = 0; i < 8; i++) begin
      tries = 0;
      acc   = 0;
      while (!acc && tries < 20) begin
        v = !gaps || tries > 3 || ($urandom_range(0, 1) == 1);
        cyc(v, b[i], 1'b1, acc);
        tries++;
      end
      if (!acc) chk("load_accept", 8'(in_ready), 8'd1);
    end
    in_load = 0;
    push_model(b);
    chk_first = 1;
  endtask

  task automatic drain(input int mode);
    bit   acc;
    logic rdy;
    int   budget = 0;
    int   stall = 0;
    while (sb.size() > 0 && budget < 300) begin
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = 1'($urandom_range(0, 1));
      else rdy = !(pops >= 3 && stall < 5);
      if (mode == 2 && !rdy) stall++;
      cyc(1'b1, 1'($urandom_range(0, 1)), rdy, acc);
      budget++;
    end
    if (sb.size() != 0) chk("drain_timeout", 8'(sb.size()), 8'd0);
    chk("triple_count", 8'(pops), 8'd11);
    cyc(1'b0, 1'b0, 1'b1, acc);
    chk("idle_no_valid", 8'(out_valid), 8'd0);
  endtask

  task automatic reset_pulse();
    reset      = 1'b1;
    in_valid   = 1'b0;
    hold_pend  = 0;
    chk_first  = 0;
    after_last = 0;
    in_load    = 0;
    #1;
    chk("rst_valid", 8'(out_valid), 8'd0);
    chk("rst_ready", 8'(in_ready), 8'd0);
    chk("rst_outs", 8'({out_data, out_tail, out_last}), 8'd0);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    #1;
    chk("post_rst_valid", 8'(out_valid), 8'd0);
    chk("post_rst_ready", 8'(in_ready), 8'd1);
    chk("post_rst_s1", 8'(dut.s1_q), 8'd0);
    chk("post_rst_s2", 8'(dut.s2_q), 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    repeat (2) @(negedge clk);
    reset_pulse();

    load(8'h00, 0);
    drain(0);

    load(8'h01, 0);
    @(posedge clk);
    #1;
    chk("first_triple_011", 8'(out_data), 8'h03);
    drain(0);

    load(8'hB5, 1);
    drain(2);

    in_load = 1;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, acc);
    in_load = 0;
    reset_pulse();
    load(8'h00, 0);
    drain(0);

    load(8'h6C, 0);
    while (pops < 4 && sb.size() > 0) cyc(1'b0, 1'b0, 1'b1, acc);
    reset_pulse();
    load(8'h00, 0);
    drain(0);

    repeat (8) begin
      load(8'($urandom), 1);
      drain(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
